// File: rtl/ysyx_22050612_muldiv.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with valid/ready on both sides and optional W-ops.
module ysyx_22050612_muldiv #(
  parameter int XLEN     = 64,
  parameter int WORD_OPS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int CW  = $clog2(XLEN) + 1;
  localparam int W2  = 2 * XLEN;
  localparam int WSH = (XLEN == 64) ? 32 : 0;
  localparam bit W_OK = (WORD_OPS != 0) && (XLEN == 64);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  state_t r_state, w_next;

  logic [CW-1:0]   r_cnt;
  logic            r_w, r_div, r_hi, r_rem, r_negq, r_negr;
  logic [W2-1:0]   r_p, r_m;
  logic [XLEN-1:0] r_q, r_r, r_result;

  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
    logic [XLEN-1:0] t;
    t = (sgn && v[31]) ? '1 : '0;
    t[31:0] = v;
    return t;
  endfunction

  // request decode
  logic            w_word, w_div, w_rem, w_s1, w_s2, w_n1, w_n2;
  logic            w_zero, w_ovf, w_special, w_accept;
  logic [XLEN-1:0] w_e1, w_e2, w_m1, w_m2, w_dvd, w_spec_res;

  assign w_word = W_OK && word;
  assign w_div  = op[2];
  assign w_rem  = op[1];

  always_comb begin
    w_s1 = 1'b0;
    w_s2 = 1'b0;
    if (w_word && !w_div) begin
      w_s1 = 1'b1;
      w_s2 = 1'b1;
    end else begin
      case (op)
        3'd0, 3'd1, 3'd4, 3'd6: begin w_s1 = 1'b1; w_s2 = 1'b1; end
        3'd2:                   w_s1 = 1'b1;
        default:                ;
      endcase
    end
  end

  assign w_e1 = w_word ? ext32(src1[31:0], w_s1) : src1;
  assign w_e2 = w_word ? ext32(src2[31:0], w_s2) : src2;
  assign w_n1 = w_s1 && w_e1[XLEN-1];
  assign w_n2 = w_s2 && w_e2[XLEN-1];
  assign w_m1 = w_n1 ? ('0 - w_e1) : w_e1;
  assign w_m2 = w_n2 ? ('0 - w_e2) : w_e2;

  // divide-by-zero and signed overflow finish without iterating
  assign w_zero = w_word ? (src2[31:0] == 32'h0) : (src2 == '0);
  assign w_ovf  = w_s1 && (w_word
                  ? (src1[31:0] == 32'h8000_0000 && src2[31:0] == 32'hFFFF_FFFF)
                  : (src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1));
  assign w_special = w_div && (w_zero || w_ovf);
  assign w_dvd     = w_word ? ext32(src1[31:0], 1'b1) : src1;

  always_comb begin
    if (w_zero) w_spec_res = w_rem ? w_dvd : '1;
    else        w_spec_res = w_rem ? '0 : w_dvd;
  end

  assign in_ready  = (r_state == S_IDLE);
  assign w_accept  = in_valid && in_ready && !flush;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;

  // iteration datapath
  logic [CW-1:0]   w_n;
  logic [XLEN:0]   w_rsh, w_dsub;
  logic            w_ge;
  logic [W2-1:0]   w_pf;
  logic [XLEN-1:0] w_qf, w_rf, w_raw, w_fin;

  assign w_n    = r_w ? CW'(32) : CW'(XLEN);
  assign w_rsh  = {r_r, r_q[XLEN-1]};
  assign w_dsub = w_rsh - {1'b0, r_m[XLEN-1:0]};
  assign w_ge   = !w_dsub[XLEN];

  assign w_pf = r_negq ? ('0 - r_p) : r_p;
  assign w_qf = r_negq ? ('0 - r_q) : r_q;
  assign w_rf = r_negr ? ('0 - r_r) : r_r;

  always_comb begin
    if (r_div)            w_raw = r_rem ? w_rf : w_qf;
    else if (r_hi && !r_w) w_raw = w_pf[W2-1:XLEN];
    else                  w_raw = w_pf[XLEN-1:0];
  end
  assign w_fin = r_w ? ext32(w_raw[31:0], 1'b1) : w_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == w_n) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_w      <= 1'b0;
      r_div    <= 1'b0;
      r_hi     <= 1'b0;
      r_rem    <= 1'b0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_p      <= '0;
      r_m      <= '0;
      r_q      <= '0;
      r_r      <= '0;
      r_result <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_cnt  <= '0;
          r_w    <= w_word;
          r_div  <= w_div;
          r_hi   <= (op[1:0] != 2'd0);
          r_rem  <= w_rem;
          r_negq <= w_n1 ^ w_n2;
          r_negr <= w_n1;
          r_p    <= '0;
          r_r    <= '0;
          r_m    <= {{XLEN{1'b0}}, (w_div ? w_m2 : w_m1)};
          // W dividends are pre-aligned to the top so 32 steps consume them
          r_q    <= w_div ? (w_word ? (w_m1 << WSH) : w_m1) : w_m2;
          if (w_special) r_result <= w_spec_res;
        end
        S_CALC: begin
          if (r_cnt != w_n) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_div) begin
              r_r <= w_ge ? w_dsub[XLEN-1:0] : w_rsh[XLEN-1:0];
              r_q <= {r_q[XLEN-2:0], w_ge};
            end else begin
              if (r_q[0]) r_p <= r_p + r_m;
              r_m <= r_m << 1;
              r_q <= r_q >> 1;
            end
          end else begin
            r_result <= w_fin;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22050612_muldiv.sv
// Directed bench for the iterative mul/div unit: results, latencies,
// special cases, backpressure, flush and async reset.
module tb_ysyx_22050612_muldiv;
  logic        clk, rst, in_valid, in_ready, word, flush, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [63:0] src1, src2, result;
  int n_chk, n_fail;

  ysyx_22050612_muldiv #(.XLEN(64), .WORD_OPS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .word(word), .src1(src1), .src2(src2), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [2:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    op = o; word = w; src1 = a; src2 = b; in_valid = 1'b1;
    chk("accept_rdy", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; op = ~o; word = ~w;
    src1 = 64'hDEAD_BEEF_0BAD_F00D; src2 = 64'h0;
  endtask

  task automatic wait_done(output int lat, output logic rdy_hi);
    lat = 0; rdy_hi = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (in_ready && !out_valid) rdy_hi = 1'b1;
    end while (!out_valid && lat < 200);
  endtask

  task automatic take();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [2:0] o, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_lat);
    int lat; logic rh;
    start(o, w, a, b);
    wait_done(lat, rh);
    chk(tag, result, exp);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_rdylow"}, {63'b0, rh}, 64'd0);
    take();
  endtask

  initial begin
    int lat; logic rh, seen;
    n_chk = 0; n_fail = 0;
    rst = 1'b1; in_valid = 1'b0; op = 3'd0; word = 1'b0; src1 = '0; src2 = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_ovalid", {63'b0, out_valid}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_busy",   {63'b0, busy}, 64'd0);
    chk("rst_irdy",   {63'b0, in_ready}, 64'd1);

    op_check("mul",    3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    op_check("mulhu",  3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    op_check("mulh",   3'd1, 1'b0, '1, '1, 64'h0, 65);
    op_check("mulhsu", 3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    op_check("div",    3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    op_check("rem",    3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    op_check("divu",   3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    op_check("remu",   3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65);
    op_check("divw_ovf", 3'd4, 1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1);
    op_check("remw_ovf", 3'd6, 1'b1, 64'h0000_0000_8000_0000, '1, 64'h0, 1);
    op_check("div0",   3'd4, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    op_check("rem0",   3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    op_check("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    op_check("rem_ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 1);
    op_check("mulw",   3'd0, 1'b1, 64'hABCD_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    op_check("mulhw",  3'd3, 1'b1, 64'hABCD_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    op_check("divuw",  3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33);
    op_check("remw",   3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);

    // backpressure: result held, new requests ignored until drained
    start(3'd5, 1'b0, 64'd100, 64'd7);
    wait_done(lat, rh);
    chk("bp_lat", 64'(lat), 64'd65);
    @(negedge clk); in_valid = 1'b1; op = 3'd0; src1 = 64'd9; src2 = 64'd9;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_result", result, 64'd14);
      chk("bp_ovalid", {63'b0, out_valid}, 64'd1);
      chk("bp_irdy",   {63'b0, in_ready}, 64'd0);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("bp_irdy_next", {63'b0, in_ready}, 64'd1);
    chk("bp_drained",   {63'b0, out_valid}, 64'd0);
    op_check("bp_mul", 3'd0, 1'b0, 64'd3, 64'd5, 64'd15, 65);

    // flush mid-divide
    start(3'd4, 1'b0, 64'd1000, 64'd3);
    repeat (19) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("fl_busy", {63'b0, busy}, 64'd0);
    chk("fl_irdy", {63'b0, in_ready}, 64'd1);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("fl_no_ovalid", {63'b0, seen}, 64'd0);
    @(negedge clk); in_valid = 1'b1; flush = 1'b1; op = 3'd0; src1 = 64'd3; src2 = 64'd4;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    chk("fl_no_accept", {63'b0, busy}, 64'd0);

    // async reset mid-CALC
    start(3'd0, 1'b0, 64'h1234, 64'h5678);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("ar_ovalid", {63'b0, out_valid}, 64'd0);
    chk("ar_result", result, 64'd0);
    chk("ar_busy",   {63'b0, busy}, 64'd0);
    @(negedge clk); rst = 1'b0;
    op_check("ar_mul", 3'd0, 1'b0, 64'd3, 64'd4, 64'd12, 65);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
